mem_copy_master: RTL and testbench
==================================

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the word-count input.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: bus wait limit, used only under MEMCPY_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a copy.
REQ-006 SHALL have port src_addr  input  32  source byte address; bits [1:0] ignored.
REQ-007 SHALL have port dst_addr  input  32  destination byte address; bits [1:0] ignored.
REQ-008 SHALL have port len_words  input  LEN_W  number of 32-bit words to copy.
REQ-009 SHALL have port busy  output  1  copy in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at copy end or abort.
REQ-011 SHALL have port error  output  1  sticky bus-timeout flag.
REQ-012 SHALL have port mem_valid  output  1  bus request.
REQ-013 SHALL have port mem_addr  output  32  bus word address, bits [1:0] always 0.
REQ-014 SHALL have port mem_wdata  output  32  write data.
REQ-015 SHALL have port mem_wstrb  output  4  byte strobes; 0 = read.
REQ-016 SHALL have port mem_ready  input  1  responder completion, one-cycle pulse.
REQ-017 SHALL have port mem_rdata  input  32  read data, valid with mem_ready.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, FINISH; IDLE after reset.
REQ-019 In IDLE, start=1 SHALL latch src, dst and len; busy rises next cycle. start outside IDLE SHALL be ignored.
REQ-020 When len_words=0, start SHALL go IDLE->FINISH with no bus traffic; done high exactly one cycle after start is sampled.
REQ-021 In READ: mem_valid=1, mem_addr=src, mem_wstrb=0; on mem_valid&&mem_ready, mem_rdata SHALL be captured in a one-word buffer and the state SHALL go to WRITE.
REQ-022 In WRITE: mem_valid=1, mem_addr=dst, mem_wdata=buffer, mem_wstrb=4'hF; on mem_ready, src+=4, dst+=4, remaining-=1; next state READ if remaining>0, else FINISH.
REQ-023 mem_valid SHALL be low for exactly one cycle after each accepted transfer, before the next request.
REQ-024 mem_addr, mem_wdata and mem_wstrb SHALL stay stable while mem_valid=1 and mem_ready=0.
REQ-025 Address increments SHALL wrap modulo 2^32 with no error.
REQ-026 FINISH SHALL assert done for one cycle, drop busy and return to IDLE; a start in that same cycle SHALL be ignored.
REQ-027 mem_ready while mem_valid=0 SHALL be ignored.

Reset
REQ-028 resetn low SHALL immediately clear busy, done, error, mem_valid, mem_addr, mem_wdata and mem_wstrb to 0, and force the state to IDLE.
REQ-029 Reset during a copy SHALL abort it without a done pulse; the copy is not resumed.

Configuration
REQ-030 With MEMCPY_TIMEOUT_EN defined, a counter SHALL count consecutive cycles of mem_valid=1 without mem_ready.
REQ-031 When that counter reaches TIMEOUT_CYCLES, the block SHALL drop mem_valid, set error and go to FINISH, which pulses done.
REQ-032 error SHALL stay set until the next accepted start, which clears it.
REQ-033 Without MEMCPY_TIMEOUT_EN, the block SHALL wait for mem_ready indefinitely and error SHALL be tied to 0.

Structure
REQ-034 A shared package SHALL hold the state enum, WSTRB_READ=4'h0, WSTRB_WORD=4'hF and WORD_BYTES=4.
REQ-035 No sub-module SHALL be used; the timeout counter SHALL stay inline.

Verification
REQ-036 Bench SHALL run: src=0x100, dst=0x200, len=3, responder ready 1 cycle after valid -> reads 0x100/0x104/0x108 interleaved with writes 0x200/0x204/0x208; data matches; one done pulse.
REQ-037 Bench SHALL run: len=0 -> no mem_valid; done high exactly one cycle after start is sampled.
REQ-038 Bench SHALL run: src=0xFFFFFFFC, len=2 -> second read at address 0x00000000.
REQ-039 Bench SHALL run: start pulsed mid-copy -> ignored; latched len and addresses unchanged.
REQ-040 Bench SHALL run: resetn low during a WRITE -> all outputs 0 immediately, no done; a new copy then completes normally.
REQ-041 Bench SHALL run, with MEMCPY_TIMEOUT_EN and a responder that never answers -> mem_valid drops after 64 cycles, error=1, one done pulse; the next start clears error.

Source files
------------

// File: rtl/mem_copy_master_pkg.sv
// Shared types and constants for the word-by-word memory copy master.
package mem_copy_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0]  WSTRB_READ = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_copy_master.sv
// Copies len_words 32-bit words from src_addr to dst_addr, one read then one write per word.
// Optional bus-wait timeout with sticky error flag: define MEMCPY_TIMEOUT_EN.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start; src/dst/len latched on start
// READ   | bus read from src into the one-word buffer
// WRITE  | bus write of the buffer to dst; advance pointers
// FINISH | one-cycle done pulse, then back to IDLE
module mem_copy_master
    import mem_copy_master_pkg::*;
#(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_remaining;
    logic             r_mem_valid;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_wstrb;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_timeout;
    logic             w_last;
    logic             w_unused_addr;

    assign w_accept      = r_mem_valid && mem_ready;
    assign w_start_ok    = (r_state == IDLE) && start;
    assign w_last        = (r_remaining == LEN_W'(1));
    assign w_unused_addr = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (len_words == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (w_timeout) begin
                    w_state_nxt = FINISH;
                end else if (w_accept) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (w_timeout) begin
                    w_state_nxt = FINISH;
                end else if (w_accept) begin
                    w_state_nxt = w_last ? FINISH : READ;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus outputs are registered; every accept drops mem_valid for one cycle
    // and the request is re-raised from the now-updated address/data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= WSTRB_READ;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src       <= {src_addr[31:2], 2'b00};
                        r_dst       <= {dst_addr[31:2], 2'b00};
                        r_remaining <= len_words;
                        if (len_words != '0) begin
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {src_addr[31:2], 2'b00};
                            r_mem_wstrb <= WSTRB_READ;
                        end
                    end
                end
                READ: begin
                    if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wdata <= mem_rdata;
                        r_mem_addr  <= r_dst;
                        r_mem_wstrb <= WSTRB_WORD;
                    end else if (!r_mem_valid) begin
                        r_mem_valid <= 1'b1;
                    end
                end
                WRITE: begin
                    if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_mem_valid <= 1'b0;
                        r_src       <= r_src + WORD_BYTES;
                        r_dst       <= r_dst + WORD_BYTES;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_mem_addr  <= r_src + WORD_BYTES;
                        r_mem_wstrb <= WSTRB_READ;
                    end else if (!r_mem_valid) begin
                        r_mem_valid <= 1'b1;
                    end
                end
                default: begin
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEMCPY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_error;

    // Down-counter holds the stall cycles still allowed; terminal count at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= CNT_RELOAD;
            r_error    <= 1'b0;
        end else begin
            if (r_mem_valid && !mem_ready) begin
                if (r_wait_cnt != '0) begin
                    r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                end
            end else begin
                r_wait_cnt <= CNT_RELOAD;
            end
            if (w_start_ok) begin
                r_error <= 1'b0;
            end else if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign w_timeout = r_mem_valid && !mem_ready && (r_wait_cnt == '0);
    assign error     = r_error;
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign error        = 1'b0;
    assign w_unused_cfg = (TIMEOUT_CYCLES != 0) && w_start_ok;
`endif

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FINISH);
    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: expected bus transfers are queued by the
// stimulus and popped by an independent monitor on every accepted transfer.
module tb_mem_copy_master;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic        busy, done, error;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int    n_cmp = 0;
    int    n_err = 0;
    int    n_done = 0;
    int    n_valid = 0;
    bit    rsp_en = 1'b1;
    xfer_t exp_q[$];

    mem_copy_master #(.LEN_W(16), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .error(error),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rd(input logic [31:0] a);
        exp_q.push_back('{addr: a, wstrb: 4'h0, wdata: 32'h0});
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] src);
        exp_q.push_back('{addr: a, wstrb: 4'hF, wdata: rd_model(src)});
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  d0;
        bit  seen;
        d0   = n_done;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #3;
            if (n_done > d0) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Responder: raises mem_ready one cycle after it first sees mem_valid.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_valid && rsp_en) begin
                cnt++;
                if (cnt >= 2) begin
                    mem_ready = 1'b1;
                    mem_rdata = (mem_wstrb == 4'h0) ? rd_model(mem_addr) : 32'hDEAD_BEEF;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops, one-cycle valid gap, stall stability, done width.
    initial begin
        bit          gap_due, prev_valid, prev_ready, prev_done;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_wstrb;
        xfer_t       e;
        gap_due = 0; prev_valid = 0; prev_ready = 0; prev_done = 0;
        p_addr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                gap_due = 0; prev_valid = 0; prev_ready = 0; prev_done = 0;
                continue;
            end
            if (gap_due) begin
                check("valid_gap", 32'(mem_valid), 32'd0);
                gap_due = 0;
            end
            if (mem_valid) n_valid++;
            if (mem_valid && prev_valid && !prev_ready) begin
                check("stall_addr", mem_addr, p_addr);
                check("stall_wstrb", 32'(mem_wstrb), 32'(p_wstrb));
                if (mem_wstrb == 4'hF) check("stall_wdata", mem_wdata, p_wdata);
            end
            if (mem_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer_addr", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_addr", mem_addr, e.addr);
                    check("xfer_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
                    if (e.wstrb == 4'hF) check("xfer_wdata", mem_wdata, e.wdata);
                end
                gap_due = 1;
            end
            if (done) begin
                n_done++;
                check("done_width", 32'(prev_done), 32'd0);
            end
            prev_valid = mem_valid; prev_ready = mem_ready; prev_done = done;
            p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, v0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_valid", 32'(mem_valid), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", 32'(mem_wstrb), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Three-word copy
        push_rd(32'h100); push_wr(32'h200, 32'h100);
        push_rd(32'h104); push_wr(32'h204, 32'h104);
        push_rd(32'h108); push_wr(32'h208, 32'h108);
        d0 = n_done;
        pulse_start(32'h100, 32'h200, 16'd3);
        check("a_busy_rise", 32'(busy), 1);
        wait_done("a", 200);
        @(negedge clk); #3;
        check("a_done_count", 32'(n_done - d0), 1);
        check("a_queue_empty", 32'(exp_q.size()), 0);
        check("a_busy_fall", 32'(busy), 0);
        check("a_error", 32'(error), 0);

        // Zero-length copy
        v0 = n_valid;
        d0 = n_done;
        pulse_start(32'h1000, 32'h2000, 16'd0);
        check("z_done_next", 32'(done), 1);
        @(negedge clk); #1;
        check("z_done_once", 32'(done), 0);
        check("z_busy_idle", 32'(busy), 0);
        repeat (3) @(negedge clk);
        #3;
        check("z_no_valid", 32'(n_valid - v0), 0);
        check("z_done_count", 32'(n_done - d0), 1);

        // Address wrap
        push_rd(32'hFFFF_FFFC); push_wr(32'h300, 32'hFFFF_FFFC);
        push_rd(32'h0000_0000); push_wr(32'h304, 32'h0000_0000);
        pulse_start(32'hFFFF_FFFC, 32'h300, 16'd2);
        wait_done("w", 200);
        check("w_queue_empty", 32'(exp_q.size()), 0);

        // Start mid-copy is ignored
        push_rd(32'h400); push_wr(32'h500, 32'h400);
        push_rd(32'h404); push_wr(32'h504, 32'h404);
        d0 = n_done;
        pulse_start(32'h400, 32'h500, 16'd2);
        repeat (2) @(negedge clk);
        pulse_start(32'h900, 32'h990, 16'd7);
        wait_done("m", 200);
        repeat (4) @(negedge clk);
        #3;
        check("m_done_count", 32'(n_done - d0), 1);
        check("m_queue_empty", 32'(exp_q.size()), 0);
        check("m_busy_idle", 32'(busy), 0);

        // Reset during a write
        push_rd(32'h600);
        d0 = n_done;
        pulse_start(32'h600, 32'h700, 16'd3);
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge clk);
                #1;
                if (mem_valid && mem_wstrb == 4'hF) hit = 1;
            end
            check("r_write_seen", 32'(hit), 1);
        end
        resetn = 1'b0;
        #1;
        check("r_busy", 32'(busy), 0);
        check("r_done", 32'(done), 0);
        check("r_valid", 32'(mem_valid), 0);
        check("r_addr", mem_addr, 0);
        check("r_wdata", mem_wdata, 0);
        check("r_wstrb", 32'(mem_wstrb), 0);
        check("r_error", 32'(error), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("r_no_done", 32'(n_done - d0), 0);
        check("r_queue_empty", 32'(exp_q.size()), 0);
        check("r_idle_valid", 32'(mem_valid), 0);
        push_rd(32'h800); push_wr(32'h880, 32'h800);
        pulse_start(32'h800, 32'h880, 16'd1);
        wait_done("r2", 200);
        check("r2_queue_empty", 32'(exp_q.size()), 0);

`ifdef MEMCPY_TIMEOUT_EN
        // Responder never answers
        rsp_en = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        v0 = n_valid;
        d0 = n_done;
        pulse_start(32'hA00, 32'hB00, 16'd1);
        wait_done("t", 300);
        check("t_valid_cycles", 32'(n_valid - v0), 64);
        check("t_valid_low", 32'(mem_valid), 0);
        check("t_error_set", 32'(error), 1);
        repeat (3) @(negedge clk);
        #3;
        check("t_error_sticky", 32'(error), 1);
        check("t_done_count", 32'(n_done - d0), 1);
        rsp_en = 1'b1;
        push_rd(32'hC00); push_wr(32'hD00, 32'hC00);
        pulse_start(32'hC00, 32'hD00, 16'd1);
        check("t_error_clear", 32'(error), 0);
        wait_done("t2", 200);
        check("t2_queue_empty", 32'(exp_q.size()), 0);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
